// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response records
// and the handshake FSM state encoding.
package dmem_responder_pkg;

  typedef logic [31:0] u32;

  typedef struct packed {
    u32         addr;
    u32         wdata;
    logic       we;
    logic [3:0] strb;
  } dmem_req_t;

  typedef struct packed {
    u32   rdata;
    logic err;
  } dmem_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_array.sv
// Word-wide single-port storage with per-byte write strobes.
// Reads are registered: rdata updates only on a read access, so it holds
// the last read word for as long as the responder presents it.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AW          = 10,
  parameter int unsigned DEPTH_WORDS = 1 << AW
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    strb,
  input  logic [AW-1:0] idx,
  input  u32            wdata,
  output u32            rdata
);

  u32 mem_q [DEPTH_WORDS];
  u32 rdata_q;

  // Byte-strobed write or registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (strb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder at the far end of the MIPS memory-stage port.
// One request at a time: accept -> wait LATENCY cycles -> commit -> respond.
// Optional macro DMEM_ERR_EN flags misaligned / out-of-range accesses;
// without it, resp_err is 0, addr[1:0] is ignored and the index wraps.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic [3:0]  req_strb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q, req_d;
  logic        rd_q, rd_d;
  logic        err_q, err_d;
  logic [1:0]  act_q;

  u32          off;
  logic        acc_err;
  logic        arr_en;
  logic        arr_we;
  u32          arr_rdata;
  dmem_resp_t  resp;

  assign off = req_q.addr - BASE_ADDR;

`ifdef DMEM_ERR_EN
  assign acc_err = (req_q.addr[1:0] != 2'b00) ||
                   ({1'b0, off} >= (33'(DEPTH_WORDS) << 2));
`else
  logic unused_off;
  assign acc_err    = 1'b0;
  assign unused_off = ^{off[31:AW+2], off[1:0]};
`endif

  // Reset release is synchronised: the block only starts accepting two
  // edges after rst_n rises, and never while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) act_q <= 2'b00;
    else        act_q <= {act_q[0], 1'b1};
  end

  // Control state; the captured request payload is not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Request payload capture.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  assign req_ready = (state_q == IDLE) && act_q[1];

  // Next-state, latency countdown and commit strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rd_d    = rd_q;
    err_d   = err_q;
    arr_en  = 1'b0;
    arr_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{addr: req_addr, wdata: req_wdata, we: req_we, strb: req_strb};
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          arr_en  = !acc_err;
          arr_we  = req_q.we;
          err_d   = acc_err;
          rd_d    = !req_q.we && !acc_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_array #(
    .AW          (AW),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .strb  (req_q.strb),
    .idx   (off[AW+1:2]),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  assign resp_valid = (state_q == RESP);
  assign resp.rdata = (resp_valid && rd_q) ? arr_rdata : 32'h0;
  assign resp.err   = resp_valid && err_q;
  assign resp_rdata = resp.rdata;
  assign resp_err   = resp.err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MIPS pipeline: the far end of the memory-stage data port.
- The memory stage drives address (aluoutM), write data (writedataM), write enable and byte strobes.
- This block accepts one request at a time over a valid/ready handshake, performs the access after a programmable latency, and returns read data / write acknowledge over a second valid/ready handshake.
- Word-addressed internal storage with byte-strobed writes.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in storage (power of two, ≥ 2).
- LATENCY, 2, cycles from request accept to resp_valid assertion (legal range 1..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address (aluoutM).
- req_wdata  in  32  write data (writedataM).
- req_we  in  1  1 = write, 0 = read.
- req_strb  in  4  byte enables for writes; ignored on reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester consumes response.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  access error (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert inside block): state=IDLE; req_ready=0 while rst_n low; resp_valid=0; resp_rdata=0; resp_err=0; latency counter=0. Storage contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture addr/wdata/we/strb and load counter=LATENCY-1, then go WAIT.
  - WAIT: req_ready=0. If counter==0, commit the access, load the response registers, go RESP. Otherwise decrement.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready. On resp_valid&&resp_ready, go IDLE. Next request is accepted no earlier than the cycle after the handshake (no same-cycle turnaround).
- Latency: request accepted at edge N → resp_valid high after edge N+LATENCY.
- Commit:
  - Write: each byte i with strb[i]=1 is updated; other bytes are unchanged. strb=0 is a legal no-op that still acknowledges. resp_rdata=0.
  - Read: resp_rdata = full word at the index as of the commit cycle.
- Index: (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- Inputs while not ready are ignored; the requester must hold them stable until accepted.
- resp_ready high outside RESP has no effect.
- Reset mid-operation: a request in WAIT is discarded with no write committed. A response in RESP is dropped.
- Back-to-back accesses to the same address: a read after a write observes the written data (writes are committed before RESP).

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - Error if addr[1:0]!=0 (misaligned) or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - On error: no write, resp_rdata=0, resp_err=1. Latency and handshake are unchanged.
- Undefined:
  - resp_err tied 0.
  - addr[1:0] ignored.
  - Index wraps modulo DEPTH_WORDS.

Decomposition:
- Shared package pipes:
  - dmem_req_t struct {addr, wdata, we, strb}.
  - dmem_resp_t struct {rdata, err}.
  - dmem_state_t enum {IDLE, WAIT, RESP}.
- Shared package common: u32 (already present).
- One sub-module: dmem_array. Synchronous byte-strobed single-port storage with inputs clk, en, we, strb, idx, wdata and output rdata. The FSM and handshake stay in dmem_responder.

Test Plan:
- LATENCY=2:
  - Write addr 0x10, wdata 0xDEADBEEF, strb 4'hF, accepted at edge N → resp_valid=1 after N+2, resp_rdata=0, resp_err=0.
  - Then read 0x10 → resp_rdata=0xDEADBEEF.
- Partial write to 0x10, wdata 0x0000_00AA, strb 4'b0001 → subsequent read returns 0xDEADBEAA.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid → resp_valid and resp_rdata stay constant, req_ready=0 throughout. Release → one handshake, req_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 while in WAIT on a write to 0x20 of 0x12345678 → resp_valid=0 immediately. After reset, read 0x20 returns its prior value, not 0x12345678.
- DMEM_ERR_EN defined:
  - Read 0x13 → resp_err=1, rdata=0.
  - Write 0x1000 (DEPTH_WORDS=1024) → resp_err=1, no storage change.
- DMEM_ERR_EN undefined: write 0x1004 with 0xCAFEF00D, then read 0x4 → 0xCAFEF00D (wrap); resp_err=0.
